mdu_unit: RTL
=============

# mdu_unit

Iterative RV32M multiply/divide unit for the integer pipeline. Takes rs1/rs2 operand values read from the register file, computes one of the eight RV32M operations over several cycles, and drives the register-file write port (`rd`, `data_des`, `data_valid`) with a single-cycle write pulse. Issue control stalls on `busy`.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  issue request; sampled only when the unit is accepting
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd_in  in  5  destination register index of the issued op
- op_a  in  32  rs1 value (dividend / multiplicand)
- op_b  in  32  rs2 value (divisor / multiplier)
- busy  out  1  op in flight; new `start` ignored
- rd  out  5  write-port destination index
- data_des  out  32  write-port data
- data_valid  out  1  write-port enable, one-cycle pulse per completed op

## Operation
- States: IDLE, MUL, DIV, DONE. Reset -> IDLE; all outputs 0.
- Accepting = state IDLE or DONE. `start` while accepting latches funct3, rd_in, op_a, op_b; `start` in MUL/DIV is ignored (no queueing).
- MUL path: one 33x33 signed product of sign/zero-extended operands (MULHSU: a signed, b unsigned; MULHU: both unsigned; MUL/MULH: both signed). MUL returns product[31:0]; others product[63:32]. IDLE -> MUL -> DONE.
- DIV path: operands converted to magnitudes for DIV/REM, 32-iteration restoring unsigned division, one quotient bit per cycle. Quotient negated if operand signs differ; remainder takes dividend sign. IDLE -> DIV (32 cycles) -> DONE.
- Special cases, decided at accept, bypass iteration (IDLE -> DONE):
  - divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- DONE: `data_valid` = 1 for exactly this cycle, `rd`/`data_des` hold result. Without a new `start` -> IDLE; with `start` -> MUL/DIV/DONE for new op (back-to-back).
- rd_in = 0: result computed, `data_valid` suppressed (register file does not hardwire x0). `rd`/`data_des` still updated.
- `rst` in any state aborts the op: no `data_valid` pulse, outputs to 0, state IDLE next cycle.

## Timing
- `start` accepted at edge T.
- MUL*: `data_valid` high in cycle T+2.
- DIV*/REM*: `data_valid` high in cycle T+33.
- Special-case divide: `data_valid` high in cycle T+1.
- `busy` = state is MUL or DIV (registered state decode, no combinational path from `start`). Low in IDLE and DONE.
- `rd`, `data_des`, `data_valid` all registered; `data_valid` low outside DONE; `rd`/`data_des` hold last result until next completion or reset.
- Operand inputs sampled only at accept; may change freely afterwards.

## Structure
- Package `mdu_pkg`: funct3 encodings as localparams, state encoding, DIV iteration count (32).
- Sub-module `mdu_divider`: unsigned restoring divider core (load, 32 iterations, done, quotient/remainder); sign handling and special cases stay in `mdu_unit`.
- Multiplier inline (single `*` on 33-bit signed operands, one register stage).

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> T+2: data_valid=1, rd=5, data_des=0xFFFFFFEB; busy high T+1 only.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD at T+33; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; `start` pulses during DIV ignored.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, both at T+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0 at T+1.
- rd_in=0 MUL 3x4 -> data_des=12 at T+2, data_valid stays 0; back-to-back `start` in DONE cycle -> second result with no idle gap.
- `rst` asserted at T+10 of a DIV -> no data_valid ever for that op, outputs 0, busy 0 next cycle; new op after reset completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes, FSM states,
// divider iteration count and operand-signedness helpers.
package mdu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int DIV_ITERS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS);

   typedef struct packed {
      logic [2:0] funct3;
      logic [4:0] rd;
   } mdu_op_t;

   // Multiplicand is unsigned only for MULHU; multiplier is signed only for MUL/MULH.
   function automatic logic mul_a_signed(input logic [2:0] f3);
      return f3 != F3_MULHU;
   endfunction

   function automatic logic mul_b_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle after load.
// quotient/remainder show the result of the current iteration; valid when done is high.
module mdu_divider
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic                 active;
   logic [DIV_CNT_W-1:0] cnt;
   logic [XLEN-1:0]      quo;
   logic [XLEN-1:0]      rem;
   logic [XLEN-1:0]      dsr;
   logic [XLEN:0]        shifted;
   logic [XLEN:0]        diff;
   logic [XLEN-1:0]      q_next;
   logic [XLEN-1:0]      r_next;

   // Partial remainder is always below the divisor, so XLEN+1 bits hold the trial value.
   always_comb begin
      shifted = {rem, quo[XLEN-1]};
      diff    = shifted - {1'b0, dsr};
      q_next  = {quo[XLEN-2:0], ~diff[XLEN]};
      r_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   end

   assign done      = active && (cnt == DIV_CNT_W'(DIV_ITERS - 1));
   assign quotient  = q_next;
   assign remainder = r_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dsr    <= '0;
      end else if (load) begin
         active <= 1'b1;
         cnt    <= '0;
         quo    <= dividend;
         rem    <= '0;
         dsr    <= divisor;
      end else if (active) begin
         quo <= q_next;
         rem <= r_next;
         cnt <= cnt + 1'b1;
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit driving a single-cycle register-file write pulse.
// Multiply takes one registered cycle; divide runs the restoring core for 32 cycles.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [4:0]      rd_in,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] data_des,
   output logic            data_valid
);

   logic [1:0]      state;
   mdu_op_t         op_q;
   logic [XLEN:0]   ma_q;
   logic [XLEN:0]   mb_q;
   logic            neg_q;
   logic            neg_r;

   logic            accept;
   logic            is_div;
   logic            div_signed;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] special_val;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_load;
   logic            div_done;
   logic [XLEN-1:0] div_quo;
   logic [XLEN-1:0] div_rem;
   logic [XLEN-1:0] div_res;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] mul_res;

   assign busy = (state == S_MUL) || (state == S_DIV);

   // Accept-time decode: special divides are resolved here and never reach the core.
   always_comb begin
      accept      = start && ((state == S_IDLE) || (state == S_DONE));
      is_div      = funct3[2];
      div_signed  = ~funct3[0];
      div_zero    = (op_b == '0);
      div_ovf     = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      special     = is_div && (div_zero || div_ovf);
      // Overflow quotient equals op_a (the most negative value), so op_a serves both cases.
      if (div_zero) special_val = funct3[1] ? op_a : '1;
      else          special_val = funct3[1] ? '0 : op_a;
      mag_a       = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
      mag_b       = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
      div_load    = accept && is_div && !special;
   end

   mdu_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Low 2*XLEN bits of the product of sign-extended 33-bit operands equal the signed 33x33 result.
   always_comb begin
      prod    = {{(XLEN-1){ma_q[XLEN]}}, ma_q} * {{(XLEN-1){mb_q[XLEN]}}, mb_q};
      mul_res = (op_q.funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      if (op_q.funct3[1]) div_res = neg_r ? -div_rem : div_rem;
      else                div_res = neg_q ? -div_quo : div_quo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         op_q       <= '0;
         ma_q       <= '0;
         mb_q       <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         rd         <= '0;
         data_des   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            S_MUL: begin
               data_des   <= mul_res;
               rd         <= op_q.rd;
               data_valid <= (op_q.rd != '0);
               state      <= S_DONE;
            end
            S_DIV: begin
               if (div_done) begin
                  data_des   <= div_res;
                  rd         <= op_q.rd;
                  data_valid <= (op_q.rd != '0);
                  state      <= S_DONE;
               end
            end
            default: ;
         endcase

         if (accept) begin
            op_q <= '{funct3: funct3, rd: rd_in};
            if (!is_div) begin
               ma_q  <= {mul_a_signed(funct3) & op_a[XLEN-1], op_a};
               mb_q  <= {mul_b_signed(funct3) & op_b[XLEN-1], op_b};
               state <= S_MUL;
            end else if (special) begin
               data_des   <= special_val;
               rd         <= rd_in;
               data_valid <= (rd_in != '0);
               state      <= S_DONE;
            end else begin
               neg_q <= div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
               neg_r <= div_signed & op_a[XLEN-1];
               state <= S_DIV;
            end
         end else if (state == S_DONE) begin
            state <= S_IDLE;
         end
      end
   end

endmodule
